// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: FSM states,
// the row/column key map and the row-priority helper.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN,
    DEB_PRESS,
    HELD,
    DEB_REL
  } state_t;

  // Indexed [row][col]; rows and columns numbered from the top-left key.
  localparam logic [3:0] KEY_MAP [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  // Rows are active-low; when several are low the lowest index wins.
  function automatic logic [1:0] lowest_low_row(input logic [3:0] r);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!r[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scanner_sync.sv
// Two-flop synchronizer with a configurable reset value, used to bring the
// asynchronous keypad rows into the system clock domain.
module sync_2ff #(
  parameter int              WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_p0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stage_p0 <= RST_VAL;
      q        <= RST_VAL;
    end else begin
      stage_p0 <= d;
      q        <= stage_p0;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotates an active-low column drive, locks onto
// the first low row it sees, debounces press and release, reports a hex code.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 48000,
  parameter int DEBOUNCE_TICKS = 20
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [PW-1:0] DIV_LAST = PW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_TICKS - 1);

  logic [3:0]    rows_s;
  logic [PW-1:0] presc;
  logic          tick;

  state_t        state, state_n;
  logic [1:0]    col_idx, col_n;
  logic [1:0]    lock_row, lock_n;
  logic [DW-1:0] deb_cnt, deb_n;
  logic [3:0]    code_n;
  logic          valid_n;
  logic          held_n;
  logic          row_low;

  sync_2ff #(
    .WIDTH   (4),
    .RST_VAL (4'b1111)
  ) u_row_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (rows),
    .q       (rows_s)
  );

  // Scan-rate prescaler: tick marks the last clock of each scan period.
  assign tick = (presc == DIV_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  assign row_low = ~rows_s[lock_row];

  always_comb begin
    state_n = state;
    col_n   = col_idx;
    lock_n  = lock_row;
    deb_n   = deb_cnt;
    code_n  = key_code;
    valid_n = 1'b0;
    if (tick) begin
      case (state)
        SCAN: begin
          if (rows_s != 4'b1111) begin
            lock_n  = lowest_low_row(rows_s);
            deb_n   = '0;
            state_n = DEB_PRESS;
          end else begin
            col_n = col_idx + 1'b1;
          end
        end
        DEB_PRESS: begin
          if (row_low && deb_cnt == DEB_LAST) begin
            state_n = HELD;
            code_n  = KEY_MAP[lock_row][col_idx];
            valid_n = 1'b1;
          end else if (row_low) begin
            deb_n = deb_cnt + 1'b1;
          end else begin
            state_n = SCAN;
            col_n   = col_idx + 1'b1;
          end
        end
        HELD: begin
          if (!row_low) begin
            deb_n   = '0;
            state_n = DEB_REL;
          end
        end
        DEB_REL: begin
          if (!row_low && deb_cnt == DEB_LAST) begin
            state_n = SCAN;
            col_n   = col_idx + 1'b1;
          end else if (!row_low) begin
            deb_n = deb_cnt + 1'b1;
          end else begin
            state_n = HELD;
          end
        end
        default: state_n = SCAN;
      endcase
    end
    held_n = (state_n == HELD) || (state_n == DEB_REL);
  end

  // Every output is registered from the next-state values so cols,
  // key_code and key_valid all move on the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= SCAN;
      col_idx   <= 2'd0;
      lock_row  <= 2'd0;
      deb_cnt   <= '0;
      cols      <= 4'b1110;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      state     <= state_n;
      col_idx   <= col_n;
      lock_row  <= lock_n;
      deb_cnt   <= deb_n;
      cols      <= ~(4'b0001 << col_n);
      key_code  <= code_n;
      key_valid <= valid_n;
      key_held  <= held_n;
    end
  end

endmodule
